// File: rtl/sjtag_scan_seq.sv
// JTAG scan sequencer: turns command words into paced TCK bursts for the SJTAG bridge
// and collects the returned TDO bits into a response word.
module sjtag_scan_seq #(
    parameter int unsigned LOW_TICKS  = 400,
    parameter int unsigned HIGH_TICKS = 16
) (
    input  logic        clk_192MHz,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    input  logic        cmd_exit,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        TCK,
    output logic        TMS,
    output logic        TDI,
    output logic        nTRST,
    input  logic        TDO,
    output logic        busy
);

    localparam int unsigned MaxTicks = (LOW_TICKS > HIGH_TICKS) ? LOW_TICKS : HIGH_TICKS;
    localparam int unsigned TickW    = $clog2(MaxTicks + 1);
    localparam logic [TickW-1:0] LowLast  = TickW'(LOW_TICKS - 1);
    localparam logic [TickW-1:0] HighLast = TickW'(HIGH_TICKS - 1);

    localparam logic [1:0] OpTmsSeq  = 2'd0;
    localparam logic [1:0] OpShift   = 2'd1;
    localparam logic [1:0] OpReset   = 2'd2;
    localparam logic [1:0] OpIdleClk = 2'd3;

    typedef enum logic [2:0] {StIdle, StLow, StHigh, StTail, StResp} state_t;

    state_t           state;
    logic [TickW-1:0] tick;
    logic [5:0]       idx;
    logic [5:0]       n_bits;
    logic [1:0]       op;
    logic [31:0]      data;
    logic             shift_exit;

    logic [5:0] cmd_n;
    logic [5:0] idx_prev;
    logic [5:0] idx_next;

    always_comb begin
        cmd_n    = (cmd_len > 6'd32) ? 6'd32 : cmd_len;
        idx_prev = idx - 6'd1;
        idx_next = idx + 6'd1;
    end

    // Pin values for bit i of a command, packed as {TMS, TDI, nTRST}.
    function automatic logic [2:0] bit_vals(input logic [1:0] f_op, input logic [31:0] f_data,
                                            input logic [5:0] i, input logic [5:0] n,
                                            input logic f_exit);
        logic [2:0] v;
        v = 3'b001;
        unique case (f_op)
            OpTmsSeq:  v = {f_data[i[4:0]], 1'b0, 1'b1};
            OpShift:   v = {f_exit && (i == n - 6'd1), f_data[i[4:0]], 1'b1};
            OpReset:   v = 3'b100;
            OpIdleClk: v = 3'b001;
            default:   v = 3'b001;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk_192MHz) begin
        if (!rst_n) begin
            state      <= StIdle;
            tick       <= '0;
            idx        <= '0;
            n_bits     <= '0;
            op         <= '0;
            data       <= '0;
            shift_exit <= 1'b0;
            TCK        <= 1'b0;
            TMS        <= 1'b1;
            TDI        <= 1'b0;
            nTRST      <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            busy       <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        op         <= cmd_op;
                        data       <= cmd_data;
                        shift_exit <= cmd_exit;
                        n_bits     <= cmd_n;
                        rsp_data   <= '0;
                        busy       <= 1'b1;
                        cmd_ready  <= 1'b0;
                        tick       <= '0;
                        idx        <= '0;
                        if (cmd_n == 6'd0) begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= StLow;
                            {TMS, TDI, nTRST} <= bit_vals(cmd_op, cmd_data, 6'd0, cmd_n,
                                                          cmd_exit);
                        end
                    end
                end
                StLow: begin
                    if (tick == LowLast) begin
                        tick  <= '0;
                        state <= StHigh;
                        TCK   <= 1'b1;
                        // This low phase closes the previous bit's transaction.
                        if (idx != 6'd0) rsp_data[idx_prev[4:0]] <= TDO;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                StHigh: begin
                    if (tick == HighLast) begin
                        tick <= '0;
                        TCK  <= 1'b0;
                        if (idx_next == n_bits) begin
                            state <= StTail;
                        end else begin
                            idx   <= idx_next;
                            state <= StLow;
                            {TMS, TDI, nTRST} <= bit_vals(op, data, idx_next, n_bits,
                                                          shift_exit);
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                StTail: begin
                    if (tick == LowLast) begin
                        tick      <= '0;
                        rsp_data[idx[4:0]] <= TDO;
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state     <= StIdle;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/sjtag_scan_seq.md
# sjtag_scan_seq

JTAG scan sequencer that drives the TCK/TMS/TDI/nTRST inputs of the SJTAG bridge from a simple command/response interface, so host-side logic never bit-bangs TCK. Each command produces a burst of 0-32 TCK periods. TCK is paced slowly enough that every bridge transaction finishes before the next rising edge. The TDO bit the bridge returns for each edge is collected into a 32-bit response word. The block sits between the host command source and the bridge, in the bridge's 192 MHz domain.

## Interface
- LOW_TICKS, 400, TCK low-phase length in clk cycles; must be ≥1 and must exceed the worst-case bridge transaction time after a rising edge.
- HIGH_TICKS, 16, TCK high-phase length in clk cycles; must be ≥1.
- clk_192MHz  in  1  sole clock.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  operation code:
  - 0 = TMS_SEQ: TMS = cmd_data[i], TDI = 0.
  - 1 = SHIFT: TDI = cmd_data[i]; TMS = 0, except the last bit when cmd_exit = 1.
  - 2 = RESET: nTRST = 0, TMS = 1, TDI = 0.
  - 3 = IDLE_CLK: TMS = 0, TDI = 0.
- cmd_len  in  6  number of TCK periods; 0 = no clocks; 33-63 are clipped to 32.
- cmd_data  in  32  bit i is used for period i (LSB first).
- cmd_exit  in  1  SHIFT only: TMS = 1 on the final bit.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  32  bit i = TDO captured for period i; bits ≥ len are 0.
- TCK, TMS, TDI, nTRST  out  1 each  to the bridge.
- TDO  in  1  from the bridge.
- busy  out  1  high whenever the block is not in IDLE.

## Operation
- States:
  - IDLE: cmd_ready = 1.
  - LOW: TCK = 0; TMS/TDI/nTRST show the current bit.
  - HIGH: TCK = 1; the bit values are held.
  - TAIL: TCK = 0; bit values are held from the final bit.
  - RESP: rsp_valid = 1.
- IDLE → LOW (bit 0) on cmd_valid && cmd_ready with n = min(len, 32) > 0. With n = 0, IDLE → RESP directly and rsp_data = 0.
- Command fields are latched on acceptance; later changes on the cmd_* inputs are ignored.
- LOW → HIGH after LOW_TICKS cycles. HIGH → LOW (next bit) after HIGH_TICKS cycles; after the last bit, HIGH → TAIL.
- In the final cycle of each LOW or TAIL phase that follows bit i's HIGH phase, TDO is sampled into rsp_data[i].
- TAIL → RESP after LOW_TICKS cycles.
- RESP → IDLE on rsp_ready. rsp_valid and rsp_data stay stable until then, and no new command is accepted.
- Between commands, TCK = 0 and TMS/TDI keep their last values. nTRST returns to 1 in the first LOW cycle of any non-RESET command, and also on reset.
- Bit index counter: 6 bits, counting 0..n-1 with no wrap. The tick counter is wide enough for max(LOW_TICKS, HIGH_TICKS).

## Timing
- Reset values (the cycle after rst_n is sampled low): TCK = 0, TMS = 1, TDI = 0, nTRST = 1, rsp_valid = 0, rsp_data = 0, busy = 0, cmd_ready = 1 (after the state returns to IDLE). All outputs are registered.
- Acceptance in cycle 0. Bit 0 values appear in cycle 1.
- Bit k has TCK = 1 in cycles k·(L+H)+L+1 … (k+1)·(L+H), where L = LOW_TICKS and H = HIGH_TICKS.
- rsp_valid first goes high in cycle n·(L+H)+L+1. For n = 0 it goes high in cycle 1.
- cmd_ready is low from cycle 1 until the cycle after the rsp handshake.
- If rst_n goes low mid-command, the command is aborted at the next edge: outputs take their reset values and no response is produced.
- Simultaneous rsp handshake and a pending cmd_valid: the command is accepted in the following cycle, at the earliest.

## Test plan
- Reset: hold rst_n low for 3 cycles → TCK 0, TMS 1, TDI 0, nTRST 1, cmd_ready 1, rsp_valid 0, busy 0.
- L = 4, H = 2, TMS_SEQ len 5, data 0x1F → 5 TCK pulses, each 2 cycles high, with TMS = 1; rsp_valid in cycle 35.
- SHIFT len 8, data 0xA5, exit 1, TDO loopback model (TDO = TDI latched on the TCK rise):
  - TDI sequence: 1,0,1,0,0,1,0,1.
  - TMS is 0 for 7 bits, then 1.
  - rsp_data = 0x000000A5.
- len 0 → no TCK edge, rsp_valid in cycle 1, rsp_data = 0. Separately, len 40 → exactly 32 TCK pulses.
- Response backpressure:
  - Hold rsp_ready low for 10 cycles with cmd_valid high → rsp_valid and rsp_data held, cmd_ready stays 0.
  - Release rsp_ready → the next command is accepted one cycle after the handshake.
- RESET op len 3, then pull rst_n low during bit 1 of a following SHIFT len 16 → nTRST low for all 3 RESET bits; after the abort, outputs show reset values and no rsp_valid. A new command issued after reset completes normally.
